// File: rtl/lcd_pixel_serializer.sv
// Pixel-pair to single-pixel serializer for the LCD output path.
// Buffers pairs in a FIFO, tags each pixel with line/frame markers and counts drops.
module lcd_pixel_serializer #(
  parameter int IMG_PIX_W  = 8,
  parameter int W_SIZE     = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [W_SIZE-1:0]    cfg_width,
  input  logic [W_SIZE-1:0]    cfg_height,
  input  logic                 clr_err,
  input  logic                 in_valid,
  input  logic [IMG_PIX_W-1:0] in_r0,
  input  logic [IMG_PIX_W-1:0] in_g0,
  input  logic [IMG_PIX_W-1:0] in_b0,
  input  logic [IMG_PIX_W-1:0] in_r1,
  input  logic [IMG_PIX_W-1:0] in_g1,
  input  logic [IMG_PIX_W-1:0] in_b1,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [IMG_PIX_W-1:0] out_r,
  output logic [IMG_PIX_W-1:0] out_g,
  output logic [IMG_PIX_W-1:0] out_b,
  output logic                 out_sol,
  output logic                 out_eol,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 frame_done,
  output logic                 overflow,
  output logic [15:0]          drop_cnt
);

  localparam int PW     = 3 * IMG_PIX_W;
  localparam int PAIR_W = 2 * PW;
  localparam int AW     = $clog2(FIFO_DEPTH);

  localparam logic [W_SIZE-1:0] ONE     = W_SIZE'(1);
  localparam logic [AW:0]       PTR_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_P0,
    S_P1
  } state_e;

  state_e              state_q, state_d;
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic [PAIR_W-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]       pix1_q, pix1_d;
  logic [PW-1:0]       out_pix_q, out_pix_d;
  logic                sol_q, sol_d, eol_q, eol_d, sof_q, sof_d, eof_q, eof_d;
  logic [W_SIZE-1:0]   x_q, x_d, y_q, y_d;
  logic [W_SIZE-1:0]   w_q, w_d, h_q, h_d;
  logic                frame_done_q, frame_done_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  logic [PAIR_W-1:0]   in_pair, head_pair;
  logic                fifo_empty, fifo_full;
  logic [W_SIZE-1:0]   live_w, live_h;
  logic                live_ok, at_origin, have_pair, xfer;
  logic                load_p0, load_p1, pop, bypass, push, drop;
  logic                latch_cfg;
  logic [W_SIZE-1:0]   cx, cy, eff_w, eff_h;

  assign in_pair    = {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1};
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // An empty FIFO falls through, so a pair arriving while idle is shown next cycle.
  assign head_pair  = fifo_empty ? in_pair : mem[rd_ptr_q[AW-1:0]];

  assign live_w    = cfg_width & ~ONE;
  assign live_h    = cfg_height;
  assign live_ok   = (live_w != '0) && (live_h != '0);
  assign at_origin = (x_q == '0) && (y_q == '0);
  assign have_pair = !fifo_empty || in_valid;
  assign xfer      = (state_q != S_IDLE) && out_ready;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can leave it latched.
  always_comb begin
    state_d = state_q;
    load_p0 = 1'b0;
    load_p1 = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (have_pair && (!at_origin || live_ok)) begin
          load_p0 = 1'b1;
          state_d = S_P0;
        end
      end
      S_P0: begin
        if (out_ready) begin
          load_p1 = 1'b1;
          state_d = S_P1;
        end
      end
      S_P1: begin
        if (out_ready) begin
          if (have_pair) begin
            load_p0 = 1'b1;
            state_d = S_P0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bypass   = load_p0 && fifo_empty;
    pop      = load_p0 && !fifo_empty;
    push     = in_valid && !bypass && (!fifo_full || pop);
    drop     = in_valid && !bypass && !push;
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  // Coordinates track the pixel held in the output register (or the next one while idle).
  always_comb begin
    cx = x_q;
    cy = y_q;
    if (xfer) begin
      if (x_q == w_q - ONE) begin
        cx = '0;
        cy = (y_q == h_q - ONE) ? '0 : (y_q + ONE);
      end else begin
        cx = x_q + ONE;
      end
    end

    latch_cfg = (state_q == S_IDLE) && load_p0 && at_origin;
    eff_w     = latch_cfg ? live_w : w_q;
    eff_h     = latch_cfg ? live_h : h_q;
    w_d       = eff_w;
    h_d       = eff_h;
    x_d       = cx;
    y_d       = cy;

    out_pix_d = out_pix_q;
    pix1_d    = pix1_q;
    sol_d     = sol_q;
    eol_d     = eol_q;
    sof_d     = sof_q;
    eof_d     = eof_q;
    if (load_p0) begin
      out_pix_d = head_pair[PAIR_W-1:PW];
      pix1_d    = head_pair[PW-1:0];
    end else if (load_p1) begin
      out_pix_d = pix1_q;
    end
    if (load_p0 || load_p1) begin
      sol_d = (cx == '0);
      eol_d = (cx == eff_w - ONE);
      sof_d = (cx == '0) && (cy == '0);
      eof_d = (cx == eff_w - ONE) && (cy == eff_h - ONE);
    end

    frame_done_d = xfer && eof_q;
  end

  // A clear and a drop in the same cycle leave exactly that one drop recorded.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_err) begin
      overflow_d = drop;
      drop_cnt_d = drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pix1_q       <= '0;
      out_pix_q    <= '0;
      sol_q        <= 1'b0;
      eol_q        <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pix1_q       <= pix1_d;
      out_pix_q    <= out_pix_d;
      sol_q        <= sol_d;
      eol_q        <= eol_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      x_q          <= x_d;
      y_q          <= y_d;
      w_q          <= w_d;
      h_q          <= h_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= in_pair;
  end

  assign out_valid             = (state_q != S_IDLE);
  assign {out_r, out_g, out_b} = out_pix_q;
  assign out_sol               = sol_q;
  assign out_eol               = eol_q;
  assign out_sof               = sof_q;
  assign out_eof               = eof_q;
  assign frame_done            = frame_done_q;
  assign overflow              = overflow_q;
  assign drop_cnt              = drop_cnt_q;

endmodule

// File: tb/tb_lcd_pixel_serializer.sv
// Scoreboard bench for lcd_pixel_serializer: expected pixels come from a linear
// pixel-index model of the frame and are compared by an independent output monitor.
module tb_lcd_pixel_serializer;

  localparam int P  = 8;
  localparam int WS = 12;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [WS-1:0] cfg_width, cfg_height;
  logic          clr_err, in_valid, out_ready;
  logic [P-1:0]  in_r0, in_g0, in_b0, in_r1, in_g1, in_b1;
  logic          out_valid, out_sol, out_eol, out_sof, out_eof;
  logic [P-1:0]  out_r, out_g, out_b;
  logic          frame_done, overflow;
  logic [15:0]   drop_cnt;

  lcd_pixel_serializer #(.IMG_PIX_W(P), .W_SIZE(WS), .FIFO_DEPTH(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .clr_err(clr_err), .in_valid(in_valid),
    .in_r0(in_r0), .in_g0(in_g0), .in_b0(in_b0),
    .in_r1(in_r1), .in_g1(in_g1), .in_b1(in_b1),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_sol(out_sol), .out_eol(out_eol), .out_sof(out_sof), .out_eof(out_eof),
    .frame_done(frame_done), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [23:0] pix;
    logic        sol, eol, sof, eof;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: pixel index inside the current frame, dims captured at frame start.
  int m_idx = 0;
  int m_w   = 0;
  int m_h   = 0;
  bit rnd_ready = 1'b0;

  // Monitor bookkeeping.
  int          n_xfer = 0;
  int          fd_cnt = 0;
  bit          prev_stall = 1'b0;
  bit          prev_eof_x = 1'b0;
  logic [28:0] stall_snap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_px(input logic [23:0] pix);
    exp_t e;
    int   x, y;
    if (m_idx == 0) begin
      m_w = int'(cfg_width) & ~1;
      m_h = int'(cfg_height);
    end
    x     = m_idx % m_w;
    y     = m_idx / m_w;
    e.pix = pix;
    e.sol = (x == 0);
    e.eol = (x == m_w - 1);
    e.sof = (m_idx == 0);
    e.eof = (x == m_w - 1) && (y == m_h - 1);
    exp_q.push_back(e);
    m_idx++;
    if (m_idx == m_w * m_h) m_idx = 0;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  function automatic logic [47:0] rnd_pair();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic put_pair(input logic [47:0] pr, input bit dropped);
    {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1} = pr;
    in_valid = 1'b1;
    if (!dropped) begin
      push_px(pr[47:24]);
      push_px(pr[23:0]);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic finish_frame();
    while (m_idx != 0) begin
      put_pair(rnd_pair(), 1'b0);
      idle(1);
    end
  endtask

  // Output monitor: pops the scoreboard on every transfer, checks hold and frame_done.
  always @(negedge HCLK) begin
    if (HRESET) begin
      prev_stall = 1'b0;
      prev_eof_x = 1'b0;
    end else begin
      check("frame_done", 32'(frame_done), 32'(prev_eof_x));
      if (prev_stall)
        check("hold_stable", 32'({out_valid, out_r, out_g, out_b, out_sol, out_eol, out_sof, out_eof}),
              32'(stall_snap));
      if (frame_done) fd_cnt++;
      if (out_valid && out_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pixel_unexpected: got %0h, required no pixel (t=%0t)",
                   {out_r, out_g, out_b}, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pixel", 32'({out_r, out_g, out_b, out_sol, out_eol, out_sof, out_eof}), 32'(e));
        end
      end
      prev_eof_x = out_valid && out_ready && out_eof;
      prev_stall = out_valid && !out_ready;
      stall_snap = {out_valid, out_r, out_g, out_b, out_sol, out_eol, out_sof, out_eof};
    end
  end

  initial begin
    int          fd_base;
    logic [47:0] pr;
    logic [7:0]  px13_r;

    HRESET = 1'b1; clr_err = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1} = '0;
    cfg_width = 12'd4; cfg_height = 12'd2;

    // Reset holds every output low even with input activity.
    repeat (3) begin
      @(posedge HCLK); #1;
      in_valid = ~in_valid;
      {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1} = rnd_pair();
    end
    @(negedge HCLK);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'({out_r, out_g, out_b}), 0);
    check("rst_tags", 32'({out_sol, out_eol, out_sof, out_eof, frame_done}), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    @(posedge HCLK); #1;
    in_valid = 1'b0;
    HRESET   = 1'b0;
    idle(3);
    check("idle_after_rst", 32'(out_valid), 0);

    // Single pair in 4x2 frame: pixel0 next cycle, pixel1 after, then idle.
    fd_base = fd_cnt;
    put_pair({8'd10, 8'd20, 8'd30, 8'd11, 8'd21, 8'd31}, 1'b0);
    check("single_p0_valid", 32'(out_valid), 1);
    check("single_p0_rgb", 32'({out_r, out_g, out_b}), 32'({8'd10, 8'd20, 8'd30}));
    check("single_p0_sof_sol", 32'({out_sof, out_sol}), 32'(2'b11));
    step();
    check("single_p1_valid", 32'(out_valid), 1);
    check("single_p1_rgb", 32'({out_r, out_g, out_b}), 32'({8'd11, 8'd21, 8'd31}));
    step();
    check("single_then_idle", 32'(out_valid), 0);
    finish_frame();
    idle(5);
    check("small_frame_done_cnt", 32'(fd_cnt - fd_base), 1);

    // Full frame, one pair every other cycle.
    cfg_width = 12'd64; cfg_height = 12'd8;
    fd_base = fd_cnt;
    for (int i = 0; i < 256; i++) begin
      put_pair(rnd_pair(), 1'b0);
      idle(1);
    end
    idle(5);
    check("full_frame_overflow", 32'(overflow), 0);
    check("full_frame_done_cnt", 32'(fd_cnt - fd_base), 1);
    check("full_frame_drained", 32'(exp_q.size()), 0);

    // Random backpressure with odd-shaped config (width 11 -> 10), three frames.
    cfg_width = 12'd11; cfg_height = 12'd6;
    fd_base   = fd_cnt;
    rnd_ready = 1'b1;
    for (int i = 0; i < 90; i++) begin
      put_pair(rnd_pair(), 1'b0);
      idle($urandom_range(4, 7));
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    idle(40);
    check("rand_overflow", 32'(overflow), 0);
    check("rand_frame_done_cnt", 32'(fd_cnt - fd_base), 3);
    check("rand_drained", 32'(exp_q.size()), 0);

    // Stalled output: 16 of 20 back-to-back pairs fit, 4 are dropped.
    out_ready = 1'b0;
    put_pair(rnd_pair(), 1'b0);
    idle(2);
    for (int k = 0; k < 20; k++) put_pair(rnd_pair(), k >= 16);
    idle(2);
    check("bp_overflow", 32'(overflow), 1);
    check("bp_drop_cnt", 32'(drop_cnt), 4);
    out_ready = 1'b1;
    idle(40);
    check("bp_drained", 32'(exp_q.size()), 0);

    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr_overflow", 32'(overflow), 0);
    check("clr_drop_cnt", 32'(drop_cnt), 0);

    // clr_err coinciding with a drop leaves a count of one.
    out_ready = 1'b0;
    put_pair(rnd_pair(), 1'b0);
    idle(2);
    for (int k = 0; k < 16; k++) put_pair(rnd_pair(), 1'b0);
    clr_err = 1'b1;
    put_pair(rnd_pair(), 1'b1);
    clr_err = 1'b0;
    check("clr_drop_overflow", 32'(overflow), 1);
    check("clr_drop_cnt", 32'(drop_cnt), 1);
    out_ready = 1'b1;
    idle(40);
    check("clr_drop_drained", 32'(exp_q.size()), 0);
    finish_frame();
    idle(10);

    // Width change mid-frame only applies from the next frame.
    cfg_width = 12'd8; cfg_height = 12'd4;
    for (int i = 0; i < 5; i++) begin
      put_pair(rnd_pair(), 1'b0);
      idle(1);
    end
    cfg_width = 12'd4;
    finish_frame();
    idle(10);
    fd_base = fd_cnt;
    for (int i = 0; i < 8; i++) begin
      put_pair(rnd_pair(), 1'b0);
      idle(1);
    end
    idle(10);
    check("cfg_new_frame_done", 32'(fd_cnt - fd_base), 1);
    check("cfg_drained", 32'(exp_q.size()), 0);

    // Reset while pixel (5,1) of an 8x4 frame is held.
    cfg_width = 12'd8; cfg_height = 12'd4;
    px13_r = '0;
    for (int k = 0; k < 7; k++) begin
      pr = rnd_pair();
      if (k == 6) px13_r = pr[23:16];
      put_pair(pr, 1'b0);
      if (k < 6) idle(1);
    end
    step();
    out_ready = 1'b0;
    @(negedge HCLK);
    check("mid_held_valid", 32'(out_valid), 1);
    check("mid_held_r", 32'(out_r), 32'(px13_r));
    step();
    HRESET = 1'b1;
    exp_q.delete();
    m_idx = 0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_data", 32'({out_r, out_g, out_b, out_sol, out_eol, out_sof, out_eof}), 0);
    check("mid_rst_drop_cnt", 32'({overflow, drop_cnt}), 0);
    step();
    HRESET    = 1'b0;
    out_ready = 1'b1;
    idle(3);
    check("mid_rst_idle", 32'(out_valid), 0);
    put_pair(rnd_pair(), 1'b0);
    check("mid_rst_sof", 32'({out_valid, out_sof}), 32'(2'b11));
    finish_frame();
    idle(10);
    check("final_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
